// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the IF stage of the pipelined core.
//   After reset it spends one bubble cycle in BOOT. It then issues fetch
//   requests to instruction memory with a valid/ready handshake. It steps the
//   PC by STEP on each accepted fetch and holds it on a hazard stall.
//   Branch/jump redirects and exceptions both steer the PC.
//   A redirect that arrives while imem is not ready is parked in a one-entry
//   pending buffer (PEND state). It is applied once imem becomes ready.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset          synchronous active-high reset, overrides every input
//   stall_i        hazard freeze; blocks sequential advance only
//   redirect_i     taken branch/jump this cycle
//   redirect_pc_i  branch/jump target (low log2(STEP) bits are dropped)
//   exc_i          exception, highest priority, loads EXC_VECTOR
//   fetch_ready_i  imem accepts the current pc_o
//   pc_o           current fetch address (registered)
//   pc_plus_o      pc_o + STEP, wraps modulo 2^N (combinational)
//   fetch_valid_o  pc_o is a valid fetch request (registered)
//   flush_o        one-cycle pulse: kill the instruction held in IF/ID
//   misalign_o     one-cycle pulse: the captured redirect target was unaligned
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int             N          = 32,
  parameter logic [N-1:0]   RESET_PC   = N'(32'h0040_0000),
  parameter logic [N-1:0]   EXC_VECTOR = N'(32'h8000_0180),
  parameter int             STEP       = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [N-1:0] redirect_pc_i,
  input  logic         exc_i,
  input  logic         fetch_ready_i,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] pc_plus_o,
  output logic         fetch_valid_o,
  output logic         flush_o,
  output logic         misalign_o
);

  // STEP is a power of two, so STEP-1 is exactly the mask of the offset bits
  // that must be zero in an aligned target (empty when STEP == 1).
  localparam logic [N-1:0] STEP_V   = N'(STEP);
  localparam logic [N-1:0] LOW_MASK = N'(STEP - 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] pending_pc;

  logic [N-1:0] target_al;
  logic         target_mis;
  logic         accept;

  assign target_al  = redirect_pc_i & ~LOW_MASK;
  assign target_mis = |(redirect_pc_i & LOW_MASK);
  assign accept     = fetch_valid_o & fetch_ready_i & ~stall_i;
  assign pc_plus_o  = pc_o + STEP_V;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BOOT;
      pc_o          <= RESET_PC;
      pending_pc    <= '0;
      fetch_valid_o <= 1'b0;
      flush_o       <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      // Both pulses default low so each event yields exactly one cycle.
      flush_o    <= 1'b0;
      misalign_o <= 1'b0;

      unique case (state)
        // Single bubble cycle. The request goes valid at RESET_PC next cycle.
        BOOT: begin
          fetch_valid_o <= 1'b1;
          state         <= RUN;
        end

        RUN: begin
          if (exc_i) begin
            pc_o       <= EXC_VECTOR;
            flush_o    <= 1'b1;
            pending_pc <= '0;
          end else if (redirect_i) begin
            misalign_o <= target_mis;
            if (fetch_ready_i) begin
              // The redirect wins over a stall. The younger path is dead anyway.
              pc_o    <= target_al;
              flush_o <= 1'b1;
            end else begin
              // imem is still holding the current request. Park the target so
              // pc_o stays stable for the handshake.
              pending_pc <= target_al;
              state      <= PEND;
            end
          end else if (accept) begin
            pc_o <= pc_o + STEP_V;
          end
        end

        PEND: begin
          // Stall is ignored here. Only imem readiness releases the target.
          if (exc_i) begin
            pc_o       <= EXC_VECTOR;
            flush_o    <= 1'b1;
            pending_pc <= '0;
            state      <= RUN;
          end else if (redirect_i) begin
            // The youngest redirect replaces whatever was buffered.
            misalign_o <= target_mis;
            if (fetch_ready_i) begin
              pc_o       <= target_al;
              flush_o    <= 1'b1;
              pending_pc <= '0;
              state      <= RUN;
            end else begin
              pending_pc <= target_al;
            end
          end else if (fetch_ready_i) begin
            pc_o       <= pending_pc;
            flush_o    <= 1'b1;
            pending_pc <= '0;
            state      <= RUN;
          end
        end

        default: begin
          state         <= BOOT;
          pc_o          <= RESET_PC;
          fetch_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
